axi_wr_rr_arbiter: RTL

//  Round-robin write-channel arbiter/sequencer for the AXI bus: shares the AW/W/B path among N_MST masters.

---
 rtl/axi_arb_pkg.sv | 44 ++++
 rtl/axi_wr_rr_arbiter_rr_pick.sv | 39 +++
 rtl/axi_wr_rr_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI write/read arbiters: transaction phase
// encoding, slave index constants and the address-to-slave decoder.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_ADDR = 2'd1,
        PH_DATA = 2'd2,
        PH_RESP = 2'd3
    } phase_e;

    localparam logic [3:0] SLV_ROM     = 4'd0;
    localparam logic [3:0] SLV_IM      = 4'd1;
    localparam logic [3:0] SLV_DM      = 4'd2;
    localparam logic [3:0] SLV_SCTRL   = 4'd3;
    localparam logic [3:0] SLV_WDT     = 4'd4;
    localparam logic [3:0] SLV_DRAM    = 4'd5;
    localparam logic [3:0] SLV_EPU     = 4'd6;
    localparam logic [3:0] SLV_DMA     = 4'd7;
    localparam logic [3:0] SLV_DEFAULT = 4'd8;

    // Map an address to the slave that owns it; unmapped space goes to the
    // default slave, which answers with DECERR.
    function automatic logic [3:0] addr_decode(input logic [31:0] addr);
        logic [3:0] sel;
        sel = SLV_DEFAULT;
        if (addr[31:24] == 8'h20) begin
            sel = SLV_DRAM;
        end else begin
            case (addr[31:16])
                16'h0000: sel = SLV_ROM;
                16'h0001: sel = SLV_IM;
                16'h0002: sel = SLV_DM;
                16'h1000: sel = SLV_SCTRL;
                16'h1001: sel = SLV_WDT;
                16'h0010: sel = SLV_EPU;
                16'h0003: sel = SLV_DMA;
                default:  sel = SLV_DEFAULT;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/axi_wr_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping modulo N_MST. ptr must be below N_MST.
module rr_pick #(
    parameter int N_MST = 3
) (
    input  logic [N_MST-1:0] req,
    input  logic [1:0]       ptr,
    output logic [1:0]       id,
    output logic             found
);

    logic [2:0]       sum  [N_MST];
    logic [1:0]       cand [N_MST];
    logic [N_MST-1:0] hit;

    // Slot gi holds the master index that is gi positions behind the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < N_MST; gi++) begin : g_slot
            assign sum[gi]  = {1'b0, ptr} + 3'(gi);
            assign cand[gi] = (sum[gi] >= 3'(N_MST)) ? 2'(sum[gi] - 3'(N_MST))
                                                     : sum[gi][1:0];
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Scan from lowest priority to highest so the nearest slot wins.
    always_comb begin
        id    = '0;
        found = 1'b0;
        for (int k = N_MST - 1; k >= 0; k--) begin
            if (hit[k]) begin
                id    = cand[k];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_rr_arbiter.sv
// Round-robin write-channel arbiter: grants one master at a time, holds the
// slave routing from AW handshake through the W burst to the B handshake, and
// flags bursts whose WLAST disagrees with the latched AWLEN.
module axi_wr_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int N_MST  = 3,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [N_MST-1:0]        awvalid_m,
    input  logic [N_MST*ADDR_W-1:0] awaddr_m,
    input  logic [N_MST*LEN_W-1:0]  awlen_m,
    input  logic                    awready_s,
    input  logic                    wvalid,
    input  logic                    wready,
    input  logic                    wlast,
    input  logic                    bvalid,
    input  logic                    bready,
    output logic                    grant_vld,
    output logic [1:0]              grant_id,
    output logic [3:0]              slave_sel,
    output logic [1:0]              phase,
    output logic                    len_err
);

    phase_e             phase_reg,     phase_next;
    logic               grant_vld_reg, grant_vld_next;
    logic [1:0]         grant_id_reg,  grant_id_next;
    logic [3:0]         slave_sel_reg, slave_sel_next;
    logic               len_err_reg,   len_err_next;
    logic [1:0]         rr_ptr_reg,    rr_ptr_next;
    logic [LEN_W-1:0]   beat_cnt_reg,  beat_cnt_next;
    logic [LEN_W-1:0]   awlen_reg,     awlen_next;

    logic               pick_found;
    logic [1:0]         pick_id;
    logic [ADDR_W-1:0]  pick_addr;
    logic [LEN_W-1:0]   pick_len;
    logic               w_beat;
    logic [LEN_W-1:0]   beat_cnt_inc;
    logic [1:0]         grant_id_wrap;

    rr_pick #(
        .N_MST (N_MST)
    ) u_rr_pick (
        .req   (awvalid_m),
        .ptr   (rr_ptr_reg),
        .id    (pick_id),
        .found (pick_found)
    );

    assign pick_addr     = awaddr_m[pick_id*ADDR_W +: ADDR_W];
    assign pick_len      = awlen_m[pick_id*LEN_W +: LEN_W];
    assign w_beat        = wvalid & wready;
    assign beat_cnt_inc  = (beat_cnt_reg == {LEN_W{1'b1}}) ? beat_cnt_reg
                                                           : beat_cnt_reg + 1'b1;
    assign grant_id_wrap = (grant_id_reg == 2'(N_MST - 1)) ? 2'd0
                                                           : grant_id_reg + 2'd1;

    // State register: async clear returns every output to its idle value at once.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            phase_reg     <= PH_IDLE;
            grant_vld_reg <= 1'b0;
            grant_id_reg  <= 2'd0;
            slave_sel_reg <= SLV_DEFAULT;
            len_err_reg   <= 1'b0;
            rr_ptr_reg    <= 2'd0;
            beat_cnt_reg  <= '0;
            awlen_reg     <= '0;
        end else begin
            phase_reg     <= phase_next;
            grant_vld_reg <= grant_vld_next;
            grant_id_reg  <= grant_id_next;
            slave_sel_reg <= slave_sel_next;
            len_err_reg   <= len_err_next;
            rr_ptr_reg    <= rr_ptr_next;
            beat_cnt_reg  <= beat_cnt_next;
            awlen_reg     <= awlen_next;
        end
    end

    // Next-state logic: grant, AW handshake, beat counting with length check, B completion.
    always_comb begin
        phase_next     = phase_reg;
        grant_vld_next = grant_vld_reg;
        grant_id_next  = grant_id_reg;
        slave_sel_next = slave_sel_reg;
        len_err_next   = len_err_reg;
        rr_ptr_next    = rr_ptr_reg;
        beat_cnt_next  = beat_cnt_reg;
        awlen_next     = awlen_reg;

        case (phase_reg)
            PH_IDLE: begin
                if (pick_found) begin
                    grant_vld_next = 1'b1;
                    grant_id_next  = pick_id;
                    awlen_next     = pick_len;
                    slave_sel_next = addr_decode(pick_addr);
                    phase_next     = PH_ADDR;
                end
            end
            PH_ADDR: begin
                if (!awvalid_m[grant_id_reg]) begin
                    // Master withdrew its request; give up without rotating priority.
                    grant_vld_next = 1'b0;
                    phase_next     = PH_IDLE;
                end else if (awready_s) begin
                    beat_cnt_next = '0;
                    phase_next    = PH_DATA;
                    if (w_beat) begin
                        // First data beat landed together with the address.
                        beat_cnt_next = LEN_W'(1);
                        if (wlast) begin
                            phase_next = PH_RESP;
                            if (awlen_reg != '0) len_err_next = 1'b1;
                        end else if (awlen_reg == '0) begin
                            len_err_next = 1'b1;
                        end
                    end
                end
            end
            PH_DATA: begin
                if (w_beat) begin
                    beat_cnt_next = beat_cnt_inc;
                    if (wlast) begin
                        phase_next = PH_RESP;
                        if (beat_cnt_reg != awlen_reg) len_err_next = 1'b1;
                    end else if (beat_cnt_reg == awlen_reg) begin
                        // Burst ran past its length; keep routing until WLAST shows up.
                        len_err_next = 1'b1;
                    end
                end
            end
            PH_RESP: begin
                if (bvalid && bready) begin
                    rr_ptr_next    = grant_id_wrap;
                    grant_vld_next = 1'b0;
                    phase_next     = PH_IDLE;
                end
            end
            default: phase_next = PH_IDLE;
        endcase
    end

    assign grant_vld = grant_vld_reg;
    assign grant_id  = grant_id_reg;
    assign slave_sel = slave_sel_reg;
    assign phase     = phase_reg;
    assign len_err   = len_err_reg;

endmodule
